// File: rtl/arc4_pkg.sv
// rtl/arc4_pkg.sv - shared types and constants for the arc4 cracking pipeline
package arc4_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEN_REQ  = 3'd1,
        LEN_WAIT = 3'd2,
        STREAM   = 3'd3,
        DONE     = 3'd4,
        NOKEY    = 3'd5
    } pt_state_t;

endpackage

// File: rtl/hex_seg7.sv
// rtl/hex_seg7.sv - nibble to active-low 7-segment decoder with blank and dash modes
//  nibble  in   4  hex digit to show
//  blank   in   1  all segments off (wins over dash)
//  dash    in   1  show '-' instead of the digit
//  seg     out  7  active-low segments, gfedcba
module hex_seg7
    import arc4_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            if (dash) begin
                seg = SEG_DASH;
            end else begin
                case (nibble)
                    4'h0: seg = 7'h40;
                    4'h1: seg = 7'h79;
                    4'h2: seg = 7'h24;
                    4'h3: seg = 7'h30;
                    4'h4: seg = 7'h19;
                    4'h5: seg = 7'h12;
                    4'h6: seg = 7'h02;
                    4'h7: seg = 7'h78;
                    4'h8: seg = 7'h00;
                    4'h9: seg = 7'h10;
                    4'hA: seg = 7'h08;
                    4'hB: seg = 7'h03;
                    4'hC: seg = 7'h46;
                    4'hD: seg = 7'h21;
                    4'hE: seg = 7'h06;
                    default: seg = 7'h0E;
                endcase
            end
        end
    end

endmodule

// File: rtl/pt_streamer.sv
// rtl/pt_streamer.sv - streams length-prefixed plaintext from pt_mem and shows the key
//  clk, rst_n          clock, async active-low reset
//  start, key_valid, key   cracker result, sampled on start
//  pt_addr, pt_rddata  pt_mem read port (one-cycle read latency)
//  out_valid/ready/data/last   plaintext byte stream
//  busy, done, err     status levels
//  hex0..hex5          active-low 7-segment digits, hex0 = key[3:0]
module pt_streamer
    import arc4_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              key_valid,
    input  logic [23:0]       key,
    output logic [ADDR_W-1:0] pt_addr,
    input  logic [DATA_W-1:0] pt_rddata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3,
    output logic [6:0]        hex4,
    output logic [6:0]        hex5
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OCC_W = $clog2(BUF_DEPTH + 1) + 1;

    pt_state_t                          state;
    logic [23:0]                        key_q;
    logic                               show_key;
    logic                               show_dash;
    logic [ADDR_W-1:0]                  len;
    logic [ADDR_W-1:0]                  rd_addr;
    logic                               rd_done;
    logic                               inflight;
    logic                               inflight_last;
    logic [BUF_DEPTH-1:0][DATA_W-1:0]   buf_data;
    logic [BUF_DEPTH-1:0]               buf_last;
    logic [PTR_W-1:0]                   wr_ptr;
    logic [PTR_W-1:0]                   rd_ptr;
    logic [OCC_W-1:0]                   occ;

    logic              start_ok;
    logic              streaming;
    logic              pop;
    logic              push;
    logic              room;
    logic              issue;
    logic              issue_last;
    logic [ADDR_W-1:0] cur_len;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;

    assign start_ok  = start && (state == IDLE || state == DONE || state == NOKEY);
    assign streaming = (state == STREAM);
    assign busy      = (state == LEN_REQ) || (state == LEN_WAIT) || streaming;
    assign done      = (state == DONE) || (state == NOKEY);
    assign err       = (state == NOKEY);

    assign out_valid = streaming && (occ != '0);
    assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
    assign out_last  = out_valid && buf_last[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign push      = streaming && inflight;

    // The byte popped this cycle frees its slot before the new read returns,
    // which is what lets a 2-entry buffer sustain one byte per cycle.
    assign room = (occ + OCC_W'(inflight)) < (OCC_W'(BUF_DEPTH) + OCC_W'(pop));

    // Byte 1 is requested while the length is still on pt_rddata, so the first
    // beat appears three cycles after start.
    assign cur_len    = (state == LEN_WAIT) ? ADDR_W'(pt_rddata) : len;
    assign issue      = ((state == LEN_WAIT) && (pt_rddata != '0))
                      || (streaming && !rd_done && room);
    assign issue_last = (rd_addr == cur_len);

    // rd_addr saturates at L, so the address never wraps while streaming.
    assign pt_addr = ((state == LEN_WAIT) || streaming) ? rd_addr : '0;

    assign wr_ptr_nxt = (wr_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign rd_ptr_nxt = (rd_ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            key_q         <= '0;
            show_key      <= 1'b0;
            show_dash     <= 1'b0;
            len           <= '0;
            rd_addr       <= '0;
            rd_done       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            buf_data      <= '0;
            buf_last      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
        end else if (start_ok) begin
            key_q         <= key;
            show_key      <= key_valid;
            show_dash     <= !key_valid;
            state         <= key_valid ? LEN_REQ : NOKEY;
            len           <= '0;
            rd_addr       <= ADDR_W'(1);
            rd_done       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
        end else begin
            case (state)
                LEN_REQ:  state <= LEN_WAIT;
                LEN_WAIT: begin
                    len   <= ADDR_W'(pt_rddata);
                    state <= (pt_rddata == '0) ? DONE : STREAM;
                end
                STREAM:   if (pop && out_last) state <= DONE;
                default:  ;
            endcase

            if (issue) begin
                if (issue_last) rd_done <= 1'b1;
                else            rd_addr <= rd_addr + ADDR_W'(1);
            end
            inflight      <= issue;
            inflight_last <= issue && issue_last;

            if (push) begin
                buf_data[wr_ptr] <= pt_rddata;
                buf_last[wr_ptr] <= inflight_last;
                wr_ptr           <= wr_ptr_nxt;
            end
            if (pop) rd_ptr <= rd_ptr_nxt;

            if (push && !pop)      occ <= occ + OCC_W'(1);
            else if (pop && !push) occ <= occ - OCC_W'(1);
        end
    end

    logic [6:0] seg [6];

    for (genvar i = 0; i < 6; i++) begin : g_hex
        hex_seg7 u_seg (
            .nibble (key_q[4*i +: 4]),
            .blank  (!show_key && !show_dash),
            .dash   (show_dash),
            .seg    (seg[i])
        );
    end

    assign hex0 = seg[0];
    assign hex1 = seg[1];
    assign hex2 = seg[2];
    assign hex3 = seg[3];
    assign hex4 = seg[4];
    assign hex5 = seg[5];

endmodule

// File: tb/tb_pt_streamer.sv
// tb/tb_pt_streamer.sv - directed self-checking bench for pt_streamer
module tb_pt_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        key_valid = 1'b0;
    logic [23:0] key = '0;
    logic [7:0]  pt_addr;
    logic [7:0]  pt_rddata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy, done, err;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    logic [7:0]  mem [256];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) pt_rddata <= mem[pt_addr];

    pt_streamer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_valid(key_valid), .key(key),
        .pt_addr(pt_addr), .pt_rddata(pt_rddata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .err(err),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the negedge right after the posedge that sampled start (cycle 0).
    task automatic do_start(input logic [23:0] k, input logic kv);
        @(negedge clk);
        start = 1'b1; key = k; key_valid = kv;
        @(negedge clk);
        start = 1'b0; key_valid = 1'b0; key = '0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic run_stream(input int len, input int mode, input int budget,
                              output int beats, output int first_cyc, output int last_cyc);
        logic       stall = 1'b0;
        logic [7:0] hold_data = '0;
        logic       hold_last = 1'b0;
        bit         seen_done = 1'b0;
        beats = 0; first_cyc = -1; last_cyc = -1;
        for (int cyc = 0; cyc < budget && !seen_done; cyc++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, hold_data);
                check("stall_last", out_last, hold_last);
            end
            if (busy && cyc >= 1) check("addr_nonzero", pt_addr != 0, 1);
            if (out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (out_ready) begin
                    if (beats < len) check("beat_data", out_data, mem[beats + 1]);
                    check("beat_last", out_last, (beats + 1 == len));
                    beats++;
                    last_cyc = cyc;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1; hold_data = out_data; hold_last = out_last;
                end
            end else begin
                stall = 1'b0;
            end
            if (done) seen_done = 1'b1;
            else @(negedge clk);
        end
        check("stream_done", seen_done, 1);
    endtask

    initial begin
        int beats, first_cyc, last_cyc, done_cyc;

        // Reset values
        @(negedge clk);
        check("rst_addr", pt_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_hex0", hex0, 7'h7F);
        check("rst_hex5", hex5, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: three bytes at full rate
        mem[0] = 8'd3; mem[1] = 8'h41; mem[2] = 8'h42; mem[3] = 8'h43;
        do_start(24'h00001E, 1'b1);
        check("t1_busy", busy, 1);
        run_stream(3, 0, 30, beats, first_cyc, last_cyc);
        check("t1_beats", beats, 3);
        check("t1_first", first_cyc, 3);
        check("t1_back2back", last_cyc - first_cyc, 2);
        check("t1_err", err, 0);
        check("t1_busy_end", busy, 0);
        check("t1_addr_park", pt_addr, 0);
        check("t1_hex0", hex0, 7'h06);
        check("t1_hex1", hex1, 7'h79);
        check("t1_hex2", hex2, 7'h40);
        check("t1_hex5", hex5, 7'h40);

        // 2: same message under backpressure, restarted from DONE
        do_start(24'h00001E, 1'b1);
        check("t2_done_clr", done, 0);
        run_stream(3, 1, 40, beats, first_cyc, last_cyc);
        check("t2_beats", beats, 3);

        // 3: empty message
        mem[0] = 8'd0;
        out_ready = 1'b1;
        do_start(24'hABCDEF, 1'b1);
        done_cyc = -1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            check("t3_novalid", out_valid, 0);
            if (done && done_cyc < 0) done_cyc = cyc;
            @(negedge clk);
        end
        check("t3_done_by3", (done_cyc >= 0) && (done_cyc <= 3), 1);
        check("t3_err", err, 0);
        check("t3_hex0", hex0, 7'h0E);
        check("t3_hex5", hex5, 7'h08);

        // 4: no key
        do_start(24'h123456, 1'b0);
        for (int cyc = 0; cyc < 4; cyc++) begin
            check("t4_addr", pt_addr, 0);
            check("t4_novalid", out_valid, 0);
            @(negedge clk);
        end
        check("t4_err", err, 1);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_hex0", hex0, 7'h3F);
        check("t4_hex3", hex3, 7'h3F);
        check("t4_hex5", hex5, 7'h3F);

        // 5: maximum length with random backpressure
        mem[0] = 8'd255;
        for (int i = 1; i < 256; i++) mem[i] = 8'(i);
        do_start(24'h0000FF, 1'b1);
        run_stream(255, 2, 3000, beats, first_cyc, last_cyc);
        check("t5_beats", beats, 255);
        check("t5_err", err, 0);

        // 6: reset mid-stream, then a full clean run
        mem[0] = 8'd10;
        for (int i = 1; i <= 10; i++) mem[i] = 8'(8'h10 + i);
        out_ready = 1'b1;
        do_start(24'h00C0DE, 1'b1);
        repeat (5) @(negedge clk);
        check("t6_mid_data", out_data, 8'h13);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_data", out_data, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_addr", pt_addr, 0);
        check("t6_rst_hex0", hex0, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(24'h00C0DE, 1'b1);
        run_stream(10, 0, 40, beats, first_cyc, last_cyc);
        check("t6_beats", beats, 10);
        check("t6_first", first_cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
